// File: rtl/fme_pkg.sv
// Shared types and helpers for the FME best-candidate capture path.
package fme_pkg;

  // Width of the winner position index coming from the finder.
  localparam int IDX_W = 3;
  localparam int SET_IDX_W = IDX_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [SET_IDX_W-1:0] set;
    logic                 offset;
  } pos_t;

  // Position p lives in set p/2 at lane offset p%2.
  function automatic pos_t decode_pos(input logic [IDX_W-1:0] p);
    pos_t d;
    d.set    = p[IDX_W-1:1];
    d.offset = p[0];
    return d;
  endfunction

endpackage

// File: rtl/fme_row_fifo.sv
// First-word fall-through row FIFO; the head row is visible on rd_data
// whenever count is non-zero, and reads zero when empty.
module fme_row_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en)      count <= count + CNT_W'(1);
      else if (rd_en && !wr_en) count <= count - CNT_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/best_candidate_capture.sv
// Captures ROWS selected sub-pel rows for each finder winner and streams them
// to the residual stage through a valid/ready FWFT FIFO.
module best_candidate_capture
  import fme_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int LANES     = 8,
  parameter int NUM_SETS  = 3,
  parameter int NUM_POS   = 6,
  parameter int ROWS      = 8,
  parameter int DEPTH     = 8
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic                                    win_valid,
  input  logic [IDX_W-1:0]                        win_idx,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [NUM_SETS*(LANES+1)*DATAWIDTH-1:0] cand_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [LANES*DATAWIDTH-1:0]              out_data,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err_overlap,
  output logic                                    err_idx
);

  localparam int ROW_W = LANES * DATAWIDTH;
  localparam int SET_W = (LANES + 1) * DATAWIDTH;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RL_W  = $clog2(ROWS + 1);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] idx_q;
  logic [RL_W-1:0]  rows_left;
  logic [CNT_W-1:0] count;
  logic             done_q;
  logic [ROW_W-1:0] window;
  pos_t             pos;
  logic             idx_ok;
  logic             accept;
  logic             read;
  logic             start;

  assign pos    = decode_pos(idx_q);
  assign window = cand_in[int'(pos.set)*SET_W + int'(pos.offset)*DATAWIDTH +: ROW_W];

  assign idx_ok = int'(win_idx) < NUM_POS;
  assign start  = (state == IDLE) && win_valid && idx_ok;

  // Handshakes are masked by enable so a frozen cycle never counts a transfer.
  assign in_ready  = enable && (state == CAPTURE) && (count < CNT_W'(DEPTH));
  assign out_valid = enable && (count != '0);
  assign accept    = in_valid && in_ready;
  assign read      = out_valid && out_ready;

  assign busy        = (state != IDLE);
  assign done        = done_q && enable;
  assign err_overlap = enable && win_valid && (state != IDLE);
  assign err_idx     = enable && win_valid && !idx_ok;

  // NOTE: assigning the default first keeps this block free of inferred latches.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CAPTURE;
      CAPTURE: if (accept && rows_left == RL_W'(1)) state_nx = DRAIN;
      DRAIN:   if (read && count == CNT_W'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx_q     <= '0;
      rows_left <= '0;
      done_q    <= 1'b0;
    end else if (enable) begin
      state  <= state_nx;
      done_q <= (state == DRAIN) && (state_nx == IDLE);
      if (start) begin
        idx_q     <= win_idx;
        rows_left <= RL_W'(ROWS);
      end else if (accept) begin
        rows_left <= rows_left - RL_W'(1);
      end
    end
  end

  fme_row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (accept),
    .wr_data (window),
    .rd_en   (read),
    .rd_data (out_data),
    .count   (count)
  );

endmodule

// File: tb/tb_best_candidate_capture.sv
// Directed bench: two instances (ROWS=8 and ROWS=12) share stimulus; sel picks
// which one is observed.
module tb_best_candidate_capture;

  localparam int DW     = 8;
  localparam int LANES  = 8;
  localparam int NSETS  = 3;
  localparam int DEPTH  = 8;
  localparam int CAND_W = NSETS * (LANES + 1) * DW;
  localparam int ROW_W  = LANES * DW;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              win_valid_a, win_valid_b;
  logic [2:0]        win_idx;
  logic              in_valid;
  logic [CAND_W-1:0] cand_in;
  logic              out_ready;
  logic              sel;

  logic              in_ready_a, out_valid_a, busy_a, done_a, err_ov_a, err_idx_a;
  logic              in_ready_b, out_valid_b, busy_b, done_b, err_ov_b, err_idx_b;
  logic [ROW_W-1:0]  out_data_a, out_data_b;

  logic              in_ready_o, out_valid_o, busy_o, done_o, err_ov_o, err_idx_o;
  logic [ROW_W-1:0]  out_data_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  best_candidate_capture #(.ROWS(8)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .win_valid(win_valid_a),
    .win_idx(win_idx), .in_valid(in_valid), .in_ready(in_ready_a), .cand_in(cand_in),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .busy(busy_a), .done(done_a), .err_overlap(err_ov_a), .err_idx(err_idx_a)
  );

  best_candidate_capture #(.ROWS(12)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .win_valid(win_valid_b),
    .win_idx(win_idx), .in_valid(in_valid), .in_ready(in_ready_b), .cand_in(cand_in),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .busy(busy_b), .done(done_b), .err_overlap(err_ov_b), .err_idx(err_idx_b)
  );

  assign in_ready_o  = sel ? in_ready_b  : in_ready_a;
  assign out_valid_o = sel ? out_valid_b : out_valid_a;
  assign out_data_o  = sel ? out_data_b  : out_data_a;
  assign busy_o      = sel ? busy_b      : busy_a;
  assign done_o      = sel ? done_b      : done_a;
  assign err_ov_o    = sel ? err_ov_b    : err_ov_a;
  assign err_idx_o   = sel ? err_idx_b   : err_idx_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_win(input bit s, input logic v);
    if (s) win_valid_b = v;
    else   win_valid_a = v;
  endtask

  // Row r, set s, sample k carries 16*s + k + r.
  function automatic logic [CAND_W-1:0] make_cand(input int r);
    logic [CAND_W-1:0] v;
    v = '0;
    for (int s = 0; s < NSETS; s++)
      for (int k = 0; k <= LANES; k++)
        v[(s*(LANES+1)+k)*DW +: DW] = 8'(16*s + k + r);
    return v;
  endfunction

  function automatic logic [ROW_W-1:0] exp_row(input int idx, input int r);
    logic [ROW_W-1:0] v;
    for (int j = 0; j < LANES; j++)
      v[j*DW +: DW] = 8'(16*(idx/2) + (idx%2) + j + r);
    return v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  in_ready_o,  0);
    check({tag, "_out_valid"}, out_valid_o, 0);
    check({tag, "_out_data"},  out_data_o,  0);
    check({tag, "_busy"},      busy_o,      0);
    check({tag, "_done"},      done_o,      0);
    check({tag, "_err_ov"},    err_ov_o,    0);
    check({tag, "_err_idx"},   err_idx_o,   0);
  endtask

  // mode 0: out_ready=1, mode 1: out_ready toggles, mode 2: held off until all rows are in.
  task automatic stream(input bit s, input int idx, input int rows, input int mode,
                        input int inject_cyc, input int freeze_cyc);
    int r_in, r_out, cyc, occ;
    bit exp_ir;
    r_in = 0; r_out = 0; cyc = 0;
    sel = s;
    win_idx = 3'(idx);
    set_win(s, 1'b1);
    #2;
    check("start_busy", busy_o, 0);
    check("start_err_idx", err_idx_o, 0);
    tick();
    set_win(s, 1'b0);
    while (r_out < rows && cyc < 400) begin
      occ = r_in - r_out;
      if (cyc == freeze_cyc) begin
        enable = 0; in_valid = 1; out_ready = 1;
        repeat (5) begin
          #2;
          check("frz_in_ready", in_ready_o, 0);
          check("frz_out_valid", out_valid_o, 0);
          check("frz_busy", busy_o, 1);
          check("frz_done", done_o, 0);
          if (occ > 0) check("frz_data", out_data_o, exp_row(idx, r_out));
          tick();
        end
        enable = 1;
      end
      in_valid = (r_in < rows);
      cand_in  = make_cand(r_in);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = cyc[0];
        default: out_ready = (r_in >= rows);
      endcase
      if (cyc == inject_cyc) begin
        win_idx = 3'd1;
        set_win(s, 1'b1);
      end
      exp_ir = (r_in < rows) && (occ < DEPTH);
      #2;
      check("in_ready", in_ready_o, exp_ir);
      check("out_valid", out_valid_o, occ > 0);
      check("err_overlap", err_ov_o, cyc == inject_cyc);
      check("err_idx_quiet", err_idx_o, 0);
      check("done_low", done_o, 0);
      if (occ > 0 && out_ready) begin
        check("row", out_data_o, exp_row(idx, r_out));
        r_out++;
      end
      if (exp_ir) r_in++;
      tick();
      set_win(s, 1'b0);
      cyc++;
    end
    if (cyc >= 400) check("timeout", 0, 1);
    in_valid = 0;
    #2;
    check("done", done_o, 1);
    check("busy_end", busy_o, 0);
    check("out_valid_end", out_valid_o, 0);
    tick();
    #2;
    check("done_pulse", done_o, 0);
    tick();
  endtask

  initial begin
    reset = 0; enable = 1; win_valid_a = 0; win_valid_b = 0; win_idx = 0;
    in_valid = 0; cand_in = '0; out_ready = 0; sel = 0;
    repeat (2) @(posedge clock);
    #1;
    sel = 0; #1; check_idle("rst_a");
    sel = 1; #1; check_idle("rst_b");
    reset = 1;
    tick();

    // Basic: position 3 -> set 1, lanes 1..8.
    stream(0, 3, 8, 0, -1, -1);
    // Backpressure fills the FIFO before draining.
    stream(0, 0, 8, 2, -1, -1);
    // ROWS=12 beyond DEPTH with a toggling consumer.
    stream(1, 4, 12, 1, -1, -1);

    // Invalid index in IDLE.
    sel = 0; win_idx = 3'd6; win_valid_a = 1;
    #2;
    check("err_idx", err_idx_o, 1);
    check("err_idx_ov", err_ov_o, 0);
    check("err_idx_busy", busy_o, 0);
    tick();
    win_valid_a = 0;
    #2;
    check("err_idx_after_busy", busy_o, 0);
    check("err_idx_after", err_idx_o, 0);
    tick();

    // Overlapping winner mid-capture is ignored.
    stream(0, 5, 8, 0, 2, -1);
    // Enable held low for five cycles mid-capture.
    stream(0, 1, 8, 0, -1, 3);

    // Reset while draining with three rows still queued.
    sel = 0; win_idx = 3'd2; win_valid_a = 1;
    tick();
    win_valid_a = 0; out_ready = 0; in_valid = 1;
    for (int r = 0; r < 8; r++) begin
      cand_in = make_cand(r);
      #2;
      check("rst_fill_ready", in_ready_o, 1);
      tick();
    end
    in_valid = 0; out_ready = 1;
    for (int r = 0; r < 5; r++) begin
      #2;
      check("rst_read", out_data_o, exp_row(2, r));
      tick();
    end
    out_ready = 0;
    #2;
    check("pre_rst_busy", busy_o, 1);
    check("pre_rst_valid", out_valid_o, 1);
    check("pre_rst_data", out_data_o, exp_row(2, 5));
    reset = 0;
    #1;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_in_ready", in_ready_o, 0);
    repeat (2) begin
      @(negedge clock);
      check("rst_no_done", done_o, 0);
    end
    reset = 1;
    tick();
    stream(0, 3, 8, 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
